// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the AVR-to-SRAM bridge.
//   state_t     - bridge FSM state encoding (3 bits, visible on debug)
//   DBG_*       - bit positions inside the 8-bit debug word
//   pack_debug  - builds {state, busy, we_s, oe_s, err, 1'b0}
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_WRITE = 3'd2,
    ST_WREC  = 3'd3,
    ST_READ  = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  localparam int DBG_STATE_LSB = 5;
  localparam int DBG_BUSY      = 4;
  localparam int DBG_WE_S      = 3;
  localparam int DBG_OE_S      = 2;
  localparam int DBG_ERR       = 1;

  localparam int WAIT_CNT_W = 4;

  function automatic logic [7:0] pack_debug(input state_t st, input logic busy,
                                            input logic we_s, input logic oe_s,
                                            input logic err);
    return {st, busy, we_s, oe_s, err, 1'b0};
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// strobe_sync: multi-flop synchroniser for one active-low AVR strobe plus
// falling-edge detect.
//   clk, reset - system clock, async active-high reset (flops reset to 1)
//   strobe     - raw asynchronous strobe
//   sync       - synchronised strobe
//   fall       - high for the one cycle in which sync has just gone 1->0;
//                the FSM acts on it at the following clock edge
module strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic sync,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              sync_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain  <= '1;
      sync_d <= 1'b1;
    end else begin
      chain  <= {chain[STAGES-2:0], strobe};
      sync_d <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign fall = sync_d & ~sync;

endmodule

// File: rtl/sram_bridge.sv
// sram_bridge: turns asynchronous AVR we/oe strobes into timed SRAM
// write/read cycles.
//   clk, reset        - system clock, async active-high reset
//   we, oe            - AVR strobes, active-low, asynchronous
//   avr_addr, avr     - AVR address and bidirectional data
//   sram              - bidirectional SRAM data
//   sram_addr         - registered SRAM address (loaded in LATCH only)
//   sram_ce_n/we_n/oe_n - SRAM strobes, active-low, registered
//   busy              - high outside IDLE
//   err               - sticky, both strobes fell in the same IDLE cycle
//   debug             - {state, busy, we_s, oe_s, err, 1'b0}
module sram_bridge
  import bus_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int AWIDTH      = 19,
  parameter int WAIT        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              oe,
  input  logic [AWIDTH-1:0] avr_addr,
  inout  wire  [DWIDTH-1:0] avr,
  inout  wire  [DWIDTH-1:0] sram,
  output logic [AWIDTH-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              busy,
  output logic              err,
  output logic [7:0]        debug
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT - 1);

  state_t                  state;
  logic                    wr_flag;
  logic                    avr_drive;
  logic                    sram_drive;
  logic [DWIDTH-1:0]       data_q;
  logic [AWIDTH-1:0]       addr_q;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    we_s, oe_s, we_fall, oe_fall;

  strobe_sync #(.STAGES(SYNC_STAGES)) u_we_sync (
    .clk(clk), .reset(reset), .strobe(we), .sync(we_s), .fall(we_fall)
  );

  strobe_sync #(.STAGES(SYNC_STAGES)) u_oe_sync (
    .clk(clk), .reset(reset), .strobe(oe), .sync(oe_s), .fall(oe_fall)
  );

  // Strobes and bus enables are registered and cleared by the async reset,
  // so a reset mid-access drops them at once without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_flag    <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      avr_drive  <= 1'b0;
      sram_drive <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      sram_addr  <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Edges are only looked at here, so anything arriving while an
          // access is in flight is simply dropped.
          if (we_fall) begin
            state   <= ST_LATCH;
            busy    <= 1'b1;
            wr_flag <= 1'b1;
            data_q  <= avr;
            addr_q  <= avr_addr;
            if (oe_fall) err <= 1'b1;
          end else if (oe_fall) begin
            state   <= ST_LATCH;
            busy    <= 1'b1;
            wr_flag <= 1'b0;
            addr_q  <= avr_addr;
          end
        end
        ST_LATCH: begin
          sram_addr <= addr_q;
          wait_cnt  <= WAIT_LAST;
          sram_ce_n <= 1'b0;
          if (wr_flag) begin
            state      <= ST_WRITE;
            sram_we_n  <= 1'b0;
            sram_drive <= 1'b1;
          end else begin
            state     <= ST_READ;
            sram_oe_n <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (wait_cnt == '0) begin
            state     <= ST_WREC;
            sram_we_n <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_WREC: begin
          state      <= ST_HOLD;
          sram_ce_n  <= 1'b1;
          sram_drive <= 1'b0;
        end
        ST_READ: begin
          if (wait_cnt == '0) begin
            state     <= ST_HOLD;
            data_q    <= sram;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            avr_drive <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (wr_flag ? we_s : oe_s) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            avr_drive <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          sram_ce_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          avr_drive  <= 1'b0;
          sram_drive <= 1'b0;
        end
      endcase
    end
  end

  assign avr   = avr_drive  ? data_q : 'z;
  assign sram  = sram_drive ? data_q : 'z;
  assign debug = pack_debug(state, busy, we_s, oe_s, err);

endmodule

// File: tb/tb_sram_bridge.sv
module tb_sram_bridge;
  import bus_pkg::*;

  localparam int WAIT_A = 2;
  localparam int WAIT_B = 3;
  localparam int WAIT_C = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // instances a (WAIT=2) and b (WAIT=3) share strobes, address and AVR data
  logic        we = 1'b1, oe = 1'b1;
  logic [18:0] addr8 = '0;
  logic [7:0]  tb_avr = '0;
  logic        tb_avr_en = 1'b0;
  wire  [7:0]  avr_a, avr_b, sram_a, sram_b;
  logic [18:0] saddr_a, saddr_b;

  // instance c: 16-bit data, 24-bit address, WAIT=15
  logic        we16 = 1'b1, oe16 = 1'b1;
  logic [23:0] addr16 = '0;
  logic [15:0] tb_avr16 = '0;
  logic        tb_avr16_en = 1'b0;
  wire  [15:0] avr_c, sram_c;
  logic [23:0] saddr_c;

  logic [2:0]  ce_n_v, we_n_v, oe_n_v, busy_v, err_v;
  logic [7:0]  dbg_a, dbg_b, dbg_c;

  assign avr_a = tb_avr_en ? tb_avr : 'z;
  assign avr_b = tb_avr_en ? tb_avr : 'z;
  assign avr_c = tb_avr16_en ? tb_avr16 : 'z;

  sram_bridge #(.DWIDTH(8), .AWIDTH(19), .WAIT(WAIT_A), .SYNC_STAGES(2)) u_a (
    .clk(clk), .reset(reset), .we(we), .oe(oe), .avr_addr(addr8), .avr(avr_a),
    .sram(sram_a), .sram_addr(saddr_a), .sram_ce_n(ce_n_v[0]), .sram_we_n(we_n_v[0]),
    .sram_oe_n(oe_n_v[0]), .busy(busy_v[0]), .err(err_v[0]), .debug(dbg_a));

  sram_bridge #(.DWIDTH(8), .AWIDTH(19), .WAIT(WAIT_B), .SYNC_STAGES(2)) u_b (
    .clk(clk), .reset(reset), .we(we), .oe(oe), .avr_addr(addr8), .avr(avr_b),
    .sram(sram_b), .sram_addr(saddr_b), .sram_ce_n(ce_n_v[1]), .sram_we_n(we_n_v[1]),
    .sram_oe_n(oe_n_v[1]), .busy(busy_v[1]), .err(err_v[1]), .debug(dbg_b));

  sram_bridge #(.DWIDTH(16), .AWIDTH(24), .WAIT(WAIT_C), .SYNC_STAGES(3)) u_c (
    .clk(clk), .reset(reset), .we(we16), .oe(oe16), .avr_addr(addr16), .avr(avr_c),
    .sram(sram_c), .sram_addr(saddr_c), .sram_ce_n(ce_n_v[2]), .sram_we_n(we_n_v[2]),
    .sram_oe_n(oe_n_v[2]), .busy(busy_v[2]), .err(err_v[2]), .debug(dbg_c));

  // SRAM models: 32 words indexed by address[4:0]; word 0x10 preloaded with 3C
  logic [7:0]  mem_a [32];
  logic [7:0]  mem_b [32];
  logic [15:0] mem_c [32];

  assign sram_a = (!ce_n_v[0] && !oe_n_v[0]) ? mem_a[saddr_a[4:0]] : 'z;
  assign sram_b = (!ce_n_v[1] && !oe_n_v[1]) ? mem_b[saddr_b[4:0]] : 'z;
  assign sram_c = (!ce_n_v[2] && !oe_n_v[2]) ? mem_c[saddr_c[4:0]] : 'z;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] <= 8'h00; mem_b[i] <= 8'h00; mem_c[i] <= 16'h0000;
      end
      mem_a[16] <= 8'h3C; mem_b[16] <= 8'h3C;
    end else begin
      if (!ce_n_v[0] && !we_n_v[0]) mem_a[saddr_a[4:0]] <= sram_a;
      if (!ce_n_v[1] && !we_n_v[1]) mem_b[saddr_b[4:0]] <= sram_b;
      if (!ce_n_v[2] && !we_n_v[2]) mem_c[saddr_c[4:0]] <= sram_c;
    end
  end

  // strobe-width, data and address monitors (sampled on the falling edge)
  int we_run[3] = '{0, 0, 0};
  int oe_run[3] = '{0, 0, 0};
  int we_w[3]   = '{0, 0, 0};
  int oe_w[3]   = '{0, 0, 0};
  int we_tot[3] = '{0, 0, 0};
  int oe_tot[3] = '{0, 0, 0};
  int overlap = 0, addr_viol = 0, wunstable = 0;
  logic [7:0]  wdat_a = '0, wdat_b = '0;
  logic [15:0] wdat_c = '0;
  logic [18:0] sa_a = '0, sa_b = '0, pa_a = '0, pa_b = '0;
  logic [23:0] sa_c = '0;
  logic [2:0]  pst_a = '0, pst_b = '0;
  logic        prst = 1'b1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!we_n_v[i]) begin we_run[i]++; we_tot[i]++; end
      else if (we_run[i] != 0) begin we_w[i] = we_run[i]; we_run[i] = 0; end
      if (!oe_n_v[i]) begin oe_run[i]++; oe_tot[i]++; end
      else if (oe_run[i] != 0) begin oe_w[i] = oe_run[i]; oe_run[i] = 0; end
      if (!we_n_v[i] && !oe_n_v[i]) overlap++;
    end
    if (!we_n_v[0]) begin
      if (we_run[0] > 1 && sram_a !== wdat_a) wunstable++;
      wdat_a = sram_a;
    end
    if (!we_n_v[1]) wdat_b = sram_b;
    if (!we_n_v[2]) wdat_c = sram_c;
    if (!ce_n_v[0]) sa_a = saddr_a;
    if (!ce_n_v[1]) sa_b = saddr_b;
    if (!ce_n_v[2]) sa_c = saddr_c;
    if (!reset && !prst &&
        ((saddr_a != pa_a && pst_a != ST_LATCH) || (saddr_b != pa_b && pst_b != ST_LATCH)))
      addr_viol++;
    pa_a = saddr_a; pa_b = saddr_b;
    pst_a = dbg_a[7:5]; pst_b = dbg_b[7:5];
    prst = reset;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // undriven nets read as Z in a 4-state simulator and as 0 in a 2-state one
  function automatic logic hiz8(input logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  function automatic logic hiz16(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  // sel 0: a and b both in st; 1: a in st; 2: c in st
  task automatic wait_st(input int sel, input logic [2:0] st, input string name);
    int  n = 0;
    logic hit;
    do begin
      @(negedge clk);
      n++;
      case (sel)
        0:       hit = (dbg_a[7:5] == st) && (dbg_b[7:5] == st);
        1:       hit = (dbg_a[7:5] == st);
        default: hit = (dbg_c[7:5] == st);
      endcase
    end while (!hit && n < 80);
    check({name, "_reach_state"}, {31'd0, hit}, 32'd1);
    #2;
  endtask

  task automatic run_ab(input int idx, input logic wr, input logic [18:0] a,
                        input logic [7:0] d, input logic [7:0] ex);
    string nm;
    int    n;
    nm = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    addr8 = a;
    if (wr) begin tb_avr = d; tb_avr_en = 1'b1; we = 1'b0; end
    else oe = 1'b0;
    wait_st(0, ST_HOLD, nm);
    check({nm, "_addr_a"}, 32'(sa_a), 32'(a));
    check({nm, "_addr_b"}, 32'(sa_b), 32'(a));
    if (wr) begin
      check({nm, "_we_width_a"}, we_w[0], WAIT_A);
      check({nm, "_we_width_b"}, we_w[1], WAIT_B);
      check({nm, "_wdata_a"}, 32'(wdat_a), 32'(d));
      check({nm, "_wdata_b"}, 32'(wdat_b), 32'(d));
      check({nm, "_sram_hiz"}, {30'd0, hiz8(sram_a), hiz8(sram_b)}, 32'd3);
      @(posedge clk); #1;
      we = 1'b1; tb_avr_en = 1'b0;
      wait_st(0, ST_IDLE, nm);
      check({nm, "_busy_done"}, 32'(busy_v[1:0]), 32'd0);
    end else begin
      check({nm, "_oe_width_a"}, oe_w[0], WAIT_A);
      check({nm, "_oe_width_b"}, oe_w[1], WAIT_B);
      check({nm, "_avr_a"}, 32'(avr_a), 32'(ex));
      check({nm, "_avr_b"}, 32'(avr_b), 32'(ex));
      @(posedge clk); #1;
      oe = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (dbg_b[DBG_OE_S] != 1'b1 && n < 10);
      check({nm, "_oe_s_rise"}, 32'(dbg_b[DBG_OE_S]), 32'd1);
      check({nm, "_avr_hold_a"}, 32'(avr_a), 32'(ex));
      check({nm, "_busy_hold"}, 32'(busy_v[1:0]), 32'd3);
      @(negedge clk); #1;
      check({nm, "_busy_done"}, 32'(busy_v[1:0]), 32'd0);
      check({nm, "_avr_release"}, {30'd0, hiz8(avr_a), hiz8(avr_b)}, 32'd3);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [18:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[7];
  int   snap0, snap1;

  initial begin
    vecs[0] = '{1'b1, 19'h01234, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 19'h0000F, 8'h5A, 8'h00};
    vecs[2] = '{1'b0, 19'h01234, 8'h00, 8'hA5};
    vecs[3] = '{1'b0, 19'h00010, 8'h00, 8'h3C};
    vecs[4] = '{1'b1, 19'h7FFFF, 8'hC3, 8'h00};
    vecs[5] = '{1'b0, 19'h0000F, 8'h00, 8'h5A};
    vecs[6] = '{1'b0, 19'h7FFFF, 8'h00, 8'hC3};

    // asynchronous reset, observed before any clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_strobes", {23'd0, ce_n_v, we_n_v, oe_n_v}, 32'h1FF);
    check("rst_debug_a", 32'(dbg_a), 32'h0C);
    check("rst_debug_c", 32'(dbg_c), 32'h0C);
    check("rst_busy_err", {26'd0, busy_v, err_v}, 32'd0);
    check("rst_addr", 32'(saddr_a) | 32'(saddr_c), 32'd0);
    check("rst_bus_hiz", {28'd0, hiz8(avr_a), hiz8(sram_a), hiz16(avr_c), hiz16(sram_c)}, 32'hF);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_ab(i, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);

    // both strobes fall together: write wins, err sticks across a clean read
    snap0 = oe_tot[0];
    @(posedge clk); #1;
    addr8 = 19'h00003; tb_avr = 8'h77; tb_avr_en = 1'b1; we = 1'b0; oe = 1'b0;
    wait_st(0, ST_HOLD, "both");
    check("both_err", 32'(err_v[1:0]), 32'd3);
    check("both_err_debug", 32'(dbg_a[DBG_ERR]), 32'd1);
    check("both_wdata", 32'(wdat_a), 32'h77);
    check("both_no_read", oe_tot[0], snap0);
    @(posedge clk); #1;
    we = 1'b1; oe = 1'b1; tb_avr_en = 1'b0;
    wait_st(0, ST_IDLE, "both_idle");
    run_ab(10, 1'b0, 19'h00003, 8'h00, 8'h77);
    check("both_err_sticky", 32'(err_v[1:0]), 32'd3);

    // reset pulsed in the second WRITE cycle
    @(posedge clk); #1;
    addr8 = 19'h00005; tb_avr = 8'h11; tb_avr_en = 1'b1; we = 1'b0;
    wait_st(1, ST_WRITE, "rst_mid");
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("rst_mid_we_n", 32'(we_n_v[1:0]), 32'd3);
    check("rst_mid_ce_n", 32'(ce_n_v[1:0]), 32'd3);
    check("rst_mid_sram_hiz", {30'd0, hiz8(sram_a), hiz8(sram_b)}, 32'd3);
    check("rst_mid_state", 32'(dbg_a[7:5]), 32'(ST_IDLE));
    check("rst_mid_err_clr", 32'(err_v[1:0]), 32'd0);
    we = 1'b1; tb_avr_en = 1'b0;
    @(negedge clk); #2;
    reset = 1'b0;
    snap0 = we_tot[0]; snap1 = oe_tot[0];
    repeat (10) @(negedge clk);
    #2;
    check("rst_mid_no_strobe", we_tot[0] + oe_tot[0], snap0 + snap1);
    check("rst_mid_idle", 32'(busy_v[1:0]), 32'd0);

    // oe pulse during a write is ignored
    snap0 = oe_tot[0]; snap1 = oe_tot[1];
    @(posedge clk); #1;
    addr8 = 19'h00006; tb_avr = 8'h66; tb_avr_en = 1'b1; we = 1'b0;
    wait_st(1, ST_WRITE, "oe_ign");
    @(posedge clk); #1 oe = 1'b0;
    repeat (3) @(posedge clk);
    #1 oe = 1'b1;
    wait_st(0, ST_HOLD, "oe_ign_hold");
    check("oe_ign_wdata", 32'(wdat_a), 32'h66);
    @(posedge clk); #1;
    we = 1'b1; tb_avr_en = 1'b0;
    wait_st(0, ST_IDLE, "oe_ign_idle");
    repeat (10) @(negedge clk);
    #2;
    check("oe_ign_no_read_a", oe_tot[0], snap0);
    check("oe_ign_no_read_b", oe_tot[1], snap1);
    check("oe_ign_busy", 32'(busy_v[1:0]), 32'd0);

    // wide instance, WAIT=15, top address
    @(posedge clk); #1;
    addr16 = 24'hFFFFFF; tb_avr16 = 16'hBEEF; tb_avr16_en = 1'b1; we16 = 1'b0;
    wait_st(2, ST_HOLD, "c_wr");
    check("c_we_width", we_w[2], WAIT_C);
    check("c_wr_addr", 32'(sa_c), 32'hFFFFFF);
    check("c_wdata", 32'(wdat_c), 32'hBEEF);
    check("c_sram_hiz", {31'd0, hiz16(sram_c)}, 32'd1);
    @(posedge clk); #1;
    we16 = 1'b1; tb_avr16_en = 1'b0;
    wait_st(2, ST_IDLE, "c_wr_idle");
    @(posedge clk); #1 oe16 = 1'b0;
    wait_st(2, ST_HOLD, "c_rd");
    check("c_oe_width", oe_w[2], WAIT_C);
    check("c_readback", 32'(avr_c), 32'hBEEF);
    @(posedge clk); #1 oe16 = 1'b1;
    wait_st(2, ST_IDLE, "c_rd_idle");
    check("c_avr_release", {31'd0, hiz16(avr_c)}, 32'd1);

    check("strobe_overlap", overlap, 0);
    check("addr_outside_latch", addr_viol, 0);
    check("wdata_unstable", wunstable, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
